// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between byte sources
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      uart_tx_start,
  output logic [DATA_W-1:0]         uart_data,
  input  logic                      uart_tx_done_tick,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      timeout_err
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [WD_W-1:0]   wdog;
  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic              accept;
  logic              release_tx;
  logic [ID_W-1:0]   next_ptr;

  // Round-robin search starting at rr_ptr; descending loop leaves the closest requester
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = ID_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign next_ptr = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign busy     = (state != IDLE);

  // Next-state and handshake decode; everything is masked while reset is asserted
  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    accept      = 1'b0;
    release_tx  = 1'b0;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          accept             = 1'b1;
          state_nxt          = START;
        end
      end
      START: begin
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (uart_tx_done_tick) begin
          release_tx = 1'b1;
          state_nxt  = IDLE;
        end else if (wdog == WD_W'(TIMEOUT - 1)) begin
          release_tx  = 1'b1;
          timeout_err = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (!rst) begin
      req_ready   = '0;
      accept      = 1'b0;
      release_tx  = 1'b0;
      timeout_err = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant capture, start pulse, watchdog and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr        <= '0;
      grant_id      <= '0;
      uart_data     <= '0;
      uart_tx_start <= 1'b0;
      wdog          <= '0;
    end else begin
      uart_tx_start <= accept;
      if (accept) begin
        uart_data <= req_data[win_idx*DATA_W +: DATA_W];
        grant_id  <= win_idx;
      end
      if (state == START) begin
        wdog <= '0;
      end else if (state == WAIT_DONE) begin
        wdog <= wdog + 1'b1;
      end
      if (release_tx) begin
        rr_ptr <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          uart_tx_start;
  logic [W-1:0]  uart_data;
  logic          uart_tx_done_tick = 1'b0;
  logic          busy;
  logic [1:0]    grant_id;
  logic          timeout_err;

  int checks   = 0;
  int failures = 0;
  int rr       = 0;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .uart_tx_start     (uart_tx_start),
    .uart_data         (uart_data),
    .uart_tx_done_tick (uart_tx_done_tick),
    .busy              (busy),
    .grant_id          (grant_id),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first valid requester at or after the model pointer, cyclically
  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  // Advance one cycle; done tick is a one-cycle pulse so it is always cleared here
  task automatic cyc();
    @(posedge clk);
    #1;
    uart_tx_done_tick = 1'b0;
    #1;
  endtask

  // One arbitration round from an IDLE cycle with inputs already driven.
  // delay 1..TO: done tick k cycles after the start cycle; delay > TO: never sent.
  task automatic serve(input int delay, input bit scramble, input bit done_in_start);
    int w;
    logic [W-1:0] d;
    w = pick(req_valid);
    #1;
    if (w < 0) begin
      chk("no_ready", 32'(req_ready), 32'd0);
      cyc();
      chk("idle_stays", 32'(busy), 32'd0);
      return;
    end
    d = req_data[w*W +: W];
    chk("ready_onehot", 32'(req_ready), 32'd1 << w);
    chk("busy_idle", 32'(busy), 32'd0);
    cyc();
    chk("start_pulse", 32'(uart_tx_start), 32'd1);
    chk("start_data", 32'(uart_data), 32'(d));
    chk("start_grant", 32'(grant_id), 32'(w));
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(req_ready), 32'd0);
    if (scramble) req_data = $urandom();
    if (done_in_start) uart_tx_done_tick = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      cyc();
      chk("wait_start_low", 32'(uart_tx_start), 32'd0);
      chk("wait_data_held", 32'(uart_data), 32'(d));
      chk("wait_busy", 32'(busy), 32'd1);
      if (k == delay) begin
        uart_tx_done_tick = 1'b1;
        #1;
        chk("done_no_timeout", 32'(timeout_err), 32'd0);
        cyc();
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("no_tout_after_done", 32'(timeout_err), 32'd0);
        break;
      end else if (k == TO) begin
        chk("timeout_pulse", 32'(timeout_err), 32'd1);
        cyc();
        chk("idle_after_tout", 32'(busy), 32'd0);
        chk("tout_one_cycle", 32'(timeout_err), 32'd0);
      end else begin
        chk("tout_low", 32'(timeout_err), 32'd0);
      end
    end
    rr = (w + 1) % N;
  endtask

  initial begin
    req_valid = '1;
    req_data  = $urandom();
    rst       = 1'b0;
    repeat (3) begin
      cyc();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_start", 32'(uart_tx_start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      chk("rst_data", 32'(uart_data), 32'd0);
      chk("rst_tout", 32'(timeout_err), 32'd0);
    end
    rst       = 1'b1;
    req_valid = '0;
    cyc();

    // All four valid: order 0,1,2,3,0
    req_data  = 32'h4443_4241;
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) serve(3, 1'b0, 1'b0);

    // Single requester 2, done 10 cycles after start
    req_valid = 4'b0100;
    req_data[23:16] = 8'h30;
    serve(10, 1'b0, 1'b0);

    // Timeout on requester 1, then the next grant moves past it
    req_valid = 4'b0010;
    serve(TO + 1, 1'b0, 1'b0);
    req_valid = 4'hF;
    serve(5, 1'b0, 1'b0);

    // Done tick while idle is ignored
    req_valid = '0;
    uart_tx_done_tick = 1'b1;
    cyc();
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_start", 32'(uart_tx_start), 32'd0);

    // Done tick during START ignored; done coincident with last watchdog count wins
    req_valid = 4'hF;
    serve(TO, 1'b1, 1'b1);

    // Valid dropped before the accept edge
    req_valid = 4'b0010;
    #1;
    chk("drop_ready", 32'(req_ready), 32'd2);
    req_valid = '0;
    cyc();
    chk("drop_busy", 32'(busy), 32'd0);
    cyc();
    chk("drop_start", 32'(uart_tx_start), 32'd0);

    // Randomized rounds
    for (int i = 0; i < 40; i++) begin
      req_valid = N'($urandom_range(0, 15));
      req_data  = $urandom();
      serve($urandom_range(1, TO + 2), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    // Reset mid WAIT_DONE: pointer returns to 0 and a late done tick is ignored
    req_valid = 4'b0100;
    req_data  = 32'h00AB_0000;
    serve(2, 1'b0, 1'b0);
    #1;
    cyc();
    cyc();
    cyc();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    cyc();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    chk("mid_rst_data", 32'(uart_data), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    req_valid = '0;
    uart_tx_done_tick = 1'b1;
    cyc();
    chk("late_done_busy", 32'(busy), 32'd0);
    chk("late_done_tout", 32'(timeout_err), 32'd0);
    rr = 0;
    req_valid = 4'hF;
    req_data  = $urandom();
    serve(4, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
